uart_tx_arb: RTL and testbench

Packet arbiter sharing the UART transmit path among up to eight on-chip requesters (debug dump, loader status, core trace, etc.). It runs in the data clock domain and writes framed packets into the UART send FIFO through its `send`/`data_send` write port. Packets never interleave. Each packet carries a sync byte, the source ID and the payload length, so the host can demultiplex the single byte stream.

---
 rtl/uart_tx_arb.sv | 261 ++++++++++++++++++++++++++
 tb/tb_uart_tx_arb.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// uart_tx_arb
//   Round-robin packet arbiter that shares the UART send FIFO write port
//   among NREQ (2..8) requesters. Each granted packet goes out as:
//     0xA5, {5'b0,id}, length, payload[0..L-1] (, checksum)
//   Packets never interleave. Bytes are written through a registered
//   uart_send/uart_data port, so uart_full must be raised while at least
//   one FIFO entry is still free.
//
//   Optional feature macro: UART_ARB_CSUM_EN
//     defined   -> a trailing checksum byte (XOR of ID, length and payload
//                  bytes; sync byte excluded) ends every frame.
//     undefined -> no checksum state or register; the frame ends after the
//                  last payload byte (or after the length byte when L = 0).
//
// Ports
//   clk        data clock, shared with the UART send FIFO write side
//   rst        asynchronous reset, active low
//   req        per-requester packet pending
//   req_len    per-requester payload length, slice i = [8i+7:8i]
//   req_data   per-requester current payload byte (first-word-fall-through)
//   req_pop    per-requester advance strobe for req_data (combinational)
//   gnt        one-hot packet owner, zero while idle
//   uart_full  send FIFO almost-full (at most one entry free)
//   uart_send  registered write strobe into the send FIFO
//   uart_data  registered byte written when uart_send is high
//   busy       a packet is in progress

module uart_tx_arb #(
  parameter int unsigned NREQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] req_len,
  input  logic [NREQ*8-1:0] req_data,
  output logic [NREQ-1:0]   req_pop,
  output logic [NREQ-1:0]   gnt,
  input  logic              uart_full,
  output logic              uart_send,
  output logic [7:0]        uart_data,
  output logic              busy
);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_ID,
    S_LEN,
    S_DATA
`ifdef UART_ARB_CSUM_EN
    ,
    S_CSUM
`endif
  } state_t;

  // State after the last byte of the length/payload section.
`ifdef UART_ARB_CSUM_EN
  localparam state_t S_TAIL = S_CSUM;
`else
  localparam state_t S_TAIL = S_IDLE;
`endif

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [2:0]        id_q, id_d;
  logic [2:0]        last_q, last_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              send_q, send_d;
  logic [7:0]        data_q, data_d;
`ifdef UART_ARB_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  // Round-robin winner search and operand muxes.
  logic              win_found;
  logic [2:0]        win_idx;
  logic [7:0]        win_len;
  logic [7:0]        cur_byte;
  int unsigned       cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    // Search starts one past the previous winner, so a requester that keeps
    // req high is served again only after every other pending requester.
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (32'(last_q) + k) % NREQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = 3'(cand);
      end
    end
  end

  always_comb begin
    win_len = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_idx == 3'(i)) begin
        win_len = req_len[i*8 +: 8];
      end
    end
  end

  always_comb begin
    cur_byte = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (id_q == 3'(i)) begin
        cur_byte = req_data[i*8 +: 8];
      end
    end
  end

  // Next-state and datapath. Every emitting state stalls as a whole while
  // uart_full is high, so no byte is lost or duplicated on resume.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    last_d  = last_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    send_d  = 1'b0;
    data_d  = data_q;
`ifdef UART_ARB_CSUM_EN
    csum_d  = csum_q;
`endif

    unique case (state_q)
      S_IDLE: begin
`ifdef UART_ARB_CSUM_EN
        csum_d = '0;
`endif
        gnt_d = '0;
        if (win_found) begin
          for (int unsigned i = 0; i < NREQ; i++) begin
            gnt_d[i] = (win_idx == 3'(i));
          end
          id_d    = win_idx;
          last_d  = win_idx;
          len_d   = win_len;
          state_d = S_SYNC;
        end
      end

      S_SYNC: begin
        if (!uart_full) begin
          send_d  = 1'b1;
          data_d  = SYNC_BYTE;
          state_d = S_ID;
        end
      end

      S_ID: begin
        if (!uart_full) begin
          send_d  = 1'b1;
          data_d  = {5'b0, id_q};
`ifdef UART_ARB_CSUM_EN
          csum_d  = csum_q ^ {5'b0, id_q};
`endif
          state_d = S_LEN;
        end
      end

      S_LEN: begin
        if (!uart_full) begin
          send_d = 1'b1;
          data_d = len_q;
`ifdef UART_ARB_CSUM_EN
          csum_d = csum_q ^ len_q;
`endif
          cnt_d  = len_q;
          if (len_q == 8'd0) begin
            state_d = S_TAIL;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        // req_pop is asserted combinationally under the same condition, so
        // the byte captured here and the requester's advance share an edge.
        if (!uart_full) begin
          send_d = 1'b1;
          data_d = cur_byte;
`ifdef UART_ARB_CSUM_EN
          csum_d = csum_q ^ cur_byte;
`endif
          cnt_d  = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = S_TAIL;
          end
        end
      end

`ifdef UART_ARB_CSUM_EN
      S_CSUM: begin
        if (!uart_full) begin
          send_d  = 1'b1;
          data_d  = csum_q;
          state_d = S_IDLE;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Ownership ends on the same edge that returns to IDLE.
    if (state_q != S_IDLE && state_d == S_IDLE) begin
      gnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      last_q  <= 3'(NREQ - 1);
      len_q   <= '0;
      cnt_q   <= '0;
      send_q  <= 1'b0;
      data_q  <= '0;
`ifdef UART_ARB_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      last_q  <= last_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      send_q  <= send_d;
      data_q  <= data_d;
`ifdef UART_ARB_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    req_pop = '0;
    if (state_q == S_DATA && !uart_full) begin
      req_pop = gnt_q;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q != S_IDLE);
  assign uart_send = send_q;
  assign uart_data = data_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb
//   Scoreboard bench for uart_tx_arb (NREQ = 4). Each scenario pushes the
//   frame bytes it expects onto exp_q before raising req; the monitor pops
//   and compares every byte the DUT writes. Requesters are modelled as
//   byte arrays read through a pointer that advances on req_pop.

module tb_uart_tx_arb;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*8-1:0] req_len;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_pop;
  logic [NREQ-1:0]   gnt;
  logic              uart_full;
  logic              uart_send;
  logic [7:0]        uart_data;
  logic              busy;

  uart_tx_arb #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_len   (req_len),
    .req_data  (req_data),
    .req_pop   (req_pop),
    .gnt       (gnt),
    .uart_full (uart_full),
    .uart_send (uart_send),
    .uart_data (uart_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Requester model.
  logic [7:0] pay [NREQ][256];
  logic [7:0] ptr [NREQ] = '{default: 8'd0};
  int         pop_cnt [NREQ] = '{default: 0};

  always @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (req_pop[i] === 1'b1) begin
        ptr[i]     <= ptr[i] + 8'd1;
        pop_cnt[i] <= pop_cnt[i] + 1;
      end
    end
  end

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_data[i*8 +: 8] = pay[i][ptr[i]];
    end
  end

  // Scoreboard.
  logic [7:0] exp_q [$];
  bit         mon_en = 1'b1;
  int         checks = 0, errors = 0;
  int         mon_checks = 0, mon_errors = 0;

  always @(negedge clk) begin
    logic [7:0] e;
    if (mon_en && rst === 1'b1 && uart_send !== 1'b0) begin
      mon_checks++;
      if (exp_q.size() == 0) begin
        mon_errors++;
        $display("FAIL uart_byte: unexpected write send=%b data=%02h, queue empty", uart_send, uart_data);
      end else begin
        e = exp_q.pop_front();
        if (uart_send !== 1'b1 || uart_data !== e) begin
          mon_errors++;
          $display("FAIL uart_byte: got send=%b data=%02h, want %02h", uart_send, uart_data, e);
        end
      end
    end
  end

  task automatic push_frame(input int id, input int len, input logic [7:0] base);
    logic [7:0] cs;
    logic [7:0] b;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(id));
    exp_q.push_back(8'(len));
    cs = 8'(id) ^ 8'(len);
    for (int k = 0; k < len; k++) begin
      b = pay[id][8'(int'(base) + k)];
      exp_q.push_back(b);
      cs = cs ^ b;
    end
`ifdef UART_ARB_CSUM_EN
    exp_q.push_back(cs);
`endif
  endtask

  task automatic load_pay(input int id, input logic [7:0] base, input int len, input logic [7:0] seed);
    for (int k = 0; k < len; k++) begin
      pay[id][8'(int'(base) + k)] = seed + 8'(k * 7);
    end
  endtask

  task automatic wait_idle(output bit timed_out);
    timed_out = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        timed_out = 1'b0;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    uart_full = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    req_len = '0;
    uart_full = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (gnt !== '0 || req_pop !== '0 || uart_send !== 1'b0 || busy !== 1'b0 || uart_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b pop=%b send=%b busy=%b data=%02h, want all 0", gnt, req_pop, uart_send, busy, uart_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || gnt !== '0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b gnt=%b, want 0/0000", busy, gnt);
    end
  endtask

  task automatic test_basic();
    logic [7:0] base;
    int p0;
    bit to;
    base = ptr[0];
    pay[0][base]        = 8'h11;
    pay[0][base + 8'd1] = 8'h22;
    pay[0][base + 8'd2] = 8'h33;
    req_len[7:0] = 8'd3;
    push_frame(0, 3, base);
    p0 = pop_cnt[0];
    req[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_grant: gnt=%b busy=%b, want 0001/1", gnt, busy);
    end
    req[0] = 1'b0;
    wait_idle(to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL basic_timeout: busy still %b, want 0", busy);
    end
    checks++;
    if (pop_cnt[0] - p0 != 3) begin
      errors++;
      $display("FAIL basic_pops: got %0d, want 3", pop_cnt[0] - p0);
    end
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0 || gnt !== '0) begin
      errors++;
      $display("FAIL basic_done: left=%0d busy=%b gnt=%b, want 0/0/0000", exp_q.size(), busy, gnt);
    end
  endtask

  task automatic test_round_robin();
    int want [6] = '{0, 1, 2, 3, 0, 2};
    int got [$];
    logic [NREQ-1:0] prev;
    int idx;
    logic [7:0] b0, b2;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_len[i*8 +: 8] = 8'd1;
      load_pay(i, ptr[i], 2, 8'(8'h40 + 8'(i * 16)));
    end
    b0 = ptr[0];
    b2 = ptr[2];
    push_frame(0, 1, b0);
    push_frame(1, 1, ptr[1]);
    push_frame(2, 1, b2);
    push_frame(3, 1, ptr[3]);
    push_frame(0, 1, b0 + 8'd1);
    push_frame(2, 1, b2 + 8'd1);
    req = 4'b1111;
    prev = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (gnt !== '0 && prev === '0) begin
        checks++;
        if (!$onehot(gnt)) begin
          errors++;
          $display("FAIL rr_onehot: gnt=%b, want one-hot", gnt);
        end
        idx = -1;
        for (int i = 0; i < NREQ; i++) if (gnt[i]) idx = i;
        got.push_back(idx);
        if (idx >= 0) req[idx] = 1'b0;
        if (idx == 3) begin
          req[0] = 1'b1;
          req[2] = 1'b1;
        end
      end
      prev = gnt;
      if (got.size() == 6 && busy === 1'b0) break;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (got.size() != 6) begin
      errors++;
      $display("FAIL rr_count: got %0d grants, want 6", got.size());
    end
    for (int j = 0; j < 6 && j < got.size(); j++) begin
      checks++;
      if (got[j] != want[j]) begin
        errors++;
        $display("FAIL rr_order[%0d]: got %0d, want %0d", j, got[j], want[j]);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rr_drain: %0d bytes left, want 0", exp_q.size());
    end
  endtask

  task automatic test_stall();
    int p1;
    bit to;
    bit hit;
    for (int k = 0; k < 4; k++) pay[1][ptr[1] + 8'(k)] = 8'hD0 + 8'(k);
    req_len[15:8] = 8'd4;
    push_frame(1, 4, ptr[1]);
    p1 = pop_cnt[1];
    req[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL stall_grant: gnt=%b, want 0010", gnt);
    end
    req[1] = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (pop_cnt[1] - p1 == 2) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL stall_reach: pops=%0d, want 2", pop_cnt[1] - p1);
    end
    uart_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (uart_send !== 1'b0 || req_pop !== '0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: send=%b pop=%b busy=%b, want 0/0000/1", c, uart_send, req_pop, busy);
      end
    end
    checks++;
    if (pop_cnt[1] - p1 != 2) begin
      errors++;
      $display("FAIL stall_popcount: got %0d, want 2", pop_cnt[1] - p1);
    end
    uart_full = 1'b0;
    wait_idle(to);
    checks++;
    if (to || pop_cnt[1] - p1 != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_done: timeout=%b pops=%0d left=%0d, want 0/4/0", to, pop_cnt[1] - p1, exp_q.size());
    end
  endtask

  task automatic test_len_zero();
    int p2;
    bit to;
    req_len[23:16] = 8'd0;
    push_frame(2, 0, ptr[2]);
    p2 = pop_cnt[2];
    req[2] = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL len0_grant: gnt=%b, want 0100", gnt);
    end
    req[2] = 1'b0;
    wait_idle(to);
    checks++;
    if (to || pop_cnt[2] - p2 != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL len0_done: timeout=%b pops=%0d left=%0d, want 0/0/0", to, pop_cnt[2] - p2, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    bit hit;
    bit to;
    logic [NREQ-1:0] prev;
    req_len[7:0] = 8'd10;
    load_pay(0, ptr[0], 10, 8'h60);
    mon_en = 1'b0;
    p0 = pop_cnt[0];
    req[0] = 1'b1;
    @(negedge clk);
    req[0] = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (pop_cnt[0] - p0 >= 3) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit || req_pop !== 4'b0001) begin
      errors++;
      $display("FAIL rstmid_reach: reached=%b pop=%b, want 1/0001", hit, req_pop);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (gnt !== '0 || req_pop !== '0 || uart_send !== 1'b0 || busy !== 1'b0 || uart_data !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_outputs: gnt=%b pop=%b send=%b busy=%b data=%02h, want all 0", gnt, req_pop, uart_send, busy, uart_data);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    req_len[7:0]   = 8'd2;
    req_len[23:16] = 8'd1;
    load_pay(0, ptr[0], 2, 8'h70);
    load_pay(2, ptr[2], 1, 8'h80);
    push_frame(0, 2, ptr[0]);
    push_frame(2, 1, ptr[2]);
    req = 4'b0101;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL rstmid_first: gnt=%b, want 0001", gnt);
    end
    req[0] = 1'b0;
    hit = 1'b0;
    prev = gnt;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (gnt === 4'b0100) begin
        hit = 1'b1;
        req[2] = 1'b0;
        break;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL rstmid_second: gnt=%b, want 0100", gnt);
    end
    wait_idle(to);
    checks++;
    if (to || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rstmid_done: timeout=%b left=%0d, want 0/0", to, exp_q.size());
    end
  endtask

  task automatic test_req_drop();
    int p3;
    bit hit;
    bit to;
    req_len[31:24] = 8'd5;
    load_pay(3, ptr[3], 5, 8'h90);
    push_frame(3, 5, ptr[3]);
    p3 = pop_cnt[3];
    req[3] = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL drop_grant: gnt=%b, want 1000", gnt);
    end
    hit = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (pop_cnt[3] - p3 >= 2) begin
        hit = 1'b1;
        break;
      end
    end
    req[3] = 1'b0;
    req_len[31:24] = 8'd9;
    wait_idle(to);
    checks++;
    if (!hit || to || pop_cnt[3] - p3 != 5 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drop_done: reached=%b timeout=%b pops=%0d left=%0d, want 1/0/5/0", hit, to, pop_cnt[3] - p3, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_stall();
    test_len_zero();
    test_reset_mid();
    test_req_drop();
    repeat (3) @(negedge clk);
    checks += mon_checks;
    errors += mon_errors;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
